// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan capture block.
// Holds the segment encodings, bus geometry, FSM state codes and a multi-hot helper.
package seg_pkg;

  localparam int SEG_DIGITS = 8;
  localparam int SEG_COM_W  = 8;

  localparam logic [SEG_COM_W-1:0] SEG_MASK_FULL = 8'hFF;

  // Segment patterns on {g,f,e,d,c,b,a}; dp is never part of the decode.
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;

  localparam logic [1:0] ST_WAIT   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  typedef struct packed {
    logic       ok;
    logic [3:0] nib;
  } seg_dec_t;

  function automatic logic seg_multi_hot(input logic [SEG_COM_W-1:0] v);
    return ((v & (v - 8'd1)) != 8'd0);
  endfunction

endpackage

// File: rtl/seg_scan_capture_decode.sv
// Combinational 7-segment to hex decoder; a blank digit decodes as ok with value 0.
module seg7_decode
  import seg_pkg::*;
(
  input  logic [7:0] i_seg,
  output seg_dec_t   o_dec
);

  logic w_dp_unused;
  assign w_dp_unused = i_seg[7];

  // Table lookup on the seven segment lines.
  always_comb begin
    o_dec.ok  = 1'b1;
    o_dec.nib = 4'h0;
    case (i_seg[6:0])
      SEG_BLANK: o_dec.nib = 4'h0;
      SEG_0:     o_dec.nib = 4'h0;
      SEG_1:     o_dec.nib = 4'h1;
      SEG_2:     o_dec.nib = 4'h2;
      SEG_3:     o_dec.nib = 4'h3;
      SEG_4:     o_dec.nib = 4'h4;
      SEG_5:     o_dec.nib = 4'h5;
      SEG_6:     o_dec.nib = 4'h6;
      SEG_7:     o_dec.nib = 4'h7;
      SEG_8:     o_dec.nib = 4'h8;
      SEG_9:     o_dec.nib = 4'h9;
      SEG_A:     o_dec.nib = 4'hA;
      SEG_B:     o_dec.nib = 4'hB;
      SEG_C:     o_dec.nib = 4'hC;
      SEG_D:     o_dec.nib = 4'hD;
      SEG_E:     o_dec.nib = 4'hE;
      SEG_F:     o_dec.nib = 4'hF;
      default: begin
        o_dec.ok  = 1'b0;
        o_dec.nib = 4'h0;
      end
    endcase
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Receiver for the multiplexed 7-segment scan bus: rebuilds the eight displayed digits
// and publishes them once the same frame has been seen STABLE_FRAMES times in a row.
module seg_scan_capture
  import seg_pkg::*;
#(
  parameter int SETTLE_CYC    = 2,
  parameter int STABLE_FRAMES = 2,
  parameter int TIMEOUT_CYC   = 4096,
  parameter int COM_ACT_LOW   = 1
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [7:0]  i_com,
  input  logic [7:0]  i_ens,
  output logic [63:0] o_seg,
  output logic [31:0] o_hex,
  output logic [7:0]  o_hex_ok,
  output logic        o_frame_stb,
  output logic        o_err,
  output logic        o_stall
);

  localparam int                   IDLE_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [3:0]           L_SETTLE   = 4'(SETTLE_CYC);
  localparam logic [2:0]           L_STABLE   = 3'(STABLE_FRAMES);
  localparam logic [IDLE_W-1:0]    L_TIMEOUT  = IDLE_W'(TIMEOUT_CYC);
  localparam logic [SEG_COM_W-1:0] L_COM_IDLE = (COM_ACT_LOW != 0) ? 8'hFF : 8'h00;

  logic [SEG_COM_W-1:0] r_com;
  logic [SEG_COM_W-1:0] r_com_prev;
  logic [7:0]           r_ens;

  logic [SEG_COM_W-1:0] w_active;
  logic                 w_multi;
  logic                 w_onehot;
  logic                 w_changed;
  logic                 w_legal_chg;
  logic [2:0]           w_idx;

  logic [1:0]           r_state;
  logic [1:0]           w_state_nx;
  logic [3:0]           r_settle_cnt;
  logic [3:0]           w_settle_nx;
  logic [3:0]           w_settle_inc;
  logic                 w_capture;
  logic                 w_start_cap;
  logic [1:0]           w_restart_state;
  logic [3:0]           w_restart_cnt;
  logic                 w_restart_cap;

  logic [SEG_COM_W-1:0] r_mask;
  logic [63:0]          r_shadow;
  logic [63:0]          r_prev;
  logic [2:0]           r_match_cnt;
  logic [2:0]           w_match_nx;
  logic                 w_frame_done;
  logic [IDLE_W-1:0]    r_idle_cnt;

  seg_dec_t             w_dec [SEG_DIGITS];
  logic [31:0]          w_hex;
  logic [7:0]           w_ok;

  // Input capture; COM resets to the deselected pattern so reset never looks like a fault.
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      r_com      <= L_COM_IDLE;
      r_com_prev <= L_COM_IDLE;
      r_ens      <= 8'h00;
    end else begin
      r_com      <= i_com;
      r_com_prev <= r_com;
      r_ens      <= i_ens;
    end
  end

  assign w_active    = r_com ^ L_COM_IDLE;
  assign w_multi     = seg_multi_hot(w_active);
  assign w_onehot    = (w_active != 8'h00) && !w_multi;
  assign w_changed   = (r_com != r_com_prev);
  assign w_legal_chg = w_changed && !w_multi;

  // One-hot to index; only meaningful when w_onehot is set.
  always_comb begin
    w_idx = 3'd0;
    for (int k = 0; k < SEG_DIGITS; k++) begin
      w_idx = w_active[k] ? 3'(k) : w_idx;
    end
  end

  // A new COM value either restarts settling or, for a one-cycle settle, captures at once.
  assign w_start_cap     = (L_SETTLE == 4'd1);
  assign w_restart_cap   = w_onehot && w_start_cap;
  assign w_restart_cnt   = w_onehot ? 4'd1 : 4'd0;
  assign w_restart_state = !w_onehot ? ST_WAIT : (w_start_cap ? ST_HOLD : ST_SETTLE);
  assign w_settle_inc    = r_settle_cnt + 4'd1;

  // Digit-select FSM next-state logic.
  always_comb begin
    w_state_nx  = r_state;
    w_settle_nx = r_settle_cnt;
    w_capture   = 1'b0;
    case (r_state)
      ST_WAIT: begin
        if (w_onehot) begin
          w_state_nx  = w_restart_state;
          w_settle_nx = w_restart_cnt;
          w_capture   = w_restart_cap;
        end else begin
          w_state_nx  = ST_WAIT;
        end
      end
      ST_SETTLE: begin
        if (w_changed) begin
          w_state_nx  = w_restart_state;
          w_settle_nx = w_restart_cnt;
          w_capture   = w_restart_cap;
        end else if (w_settle_inc == L_SETTLE) begin
          w_state_nx  = ST_HOLD;
          w_settle_nx = w_settle_inc;
          w_capture   = 1'b1;
        end else begin
          w_settle_nx = w_settle_inc;
        end
      end
      ST_HOLD: begin
        if (w_changed) begin
          w_state_nx  = w_restart_state;
          w_settle_nx = w_restart_cnt;
          w_capture   = w_restart_cap;
        end else begin
          w_state_nx  = ST_HOLD;
        end
      end
      default: begin
        w_state_nx  = ST_WAIT;
        w_settle_nx = 4'd0;
      end
    endcase
  end

  // FSM state registers.
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      r_state      <= ST_WAIT;
      r_settle_cnt <= 4'd0;
    end else begin
      r_state      <= w_state_nx;
      r_settle_cnt <= w_settle_nx;
    end
  end

  for (genvar k = 0; k < SEG_DIGITS; k++) begin : g_dec
    seg7_decode u_dec (
      .i_seg (r_shadow[8*k +: 8]),
      .o_dec (w_dec[k])
    );
    assign w_hex[4*k +: 4] = w_dec[k].nib;
    assign w_ok[k]         = w_dec[k].ok;
  end

  assign w_frame_done = (r_mask == SEG_MASK_FULL);
  assign w_match_nx   = (r_shadow != r_prev)     ? 3'd1 :
                        (r_match_cnt == L_STABLE) ? L_STABLE : (r_match_cnt + 3'd1);

  // Frame assembly, stability tracking and publication.
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      r_mask      <= 8'h00;
      r_shadow    <= 64'd0;
      r_prev      <= 64'd0;
      r_match_cnt <= 3'd0;
      o_seg       <= 64'd0;
      o_hex       <= 32'd0;
      o_hex_ok    <= 8'h00;
      o_frame_stb <= 1'b0;
    end else begin
      o_frame_stb <= 1'b0;
      if (w_capture) begin
        r_shadow[{w_idx, 3'b000} +: 8] <= r_ens;
      end
      // A capture landing on the completion cycle belongs to the next frame.
      if (w_frame_done) begin
        r_prev      <= r_shadow;
        r_match_cnt <= w_match_nx;
        r_mask      <= w_capture ? w_active : 8'h00;
        if (w_match_nx == L_STABLE) begin
          o_seg       <= r_shadow;
          o_hex       <= w_hex;
          o_hex_ok    <= w_ok;
          o_frame_stb <= 1'b1;
        end
      end else if (w_capture) begin
        r_mask <= r_mask | w_active;
      end
    end
  end

  // Sticky multi-select fault and the scan-stall watchdog.
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      o_err      <= 1'b0;
      o_stall    <= 1'b0;
      r_idle_cnt <= '0;
    end else begin
      if (w_multi) begin
        o_err <= 1'b1;
      end
      if (w_legal_chg) begin
        r_idle_cnt <= '0;
        o_stall    <= 1'b0;
      end else if (r_idle_cnt == L_TIMEOUT) begin
        o_stall    <= 1'b1;
      end else begin
        r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Self-checking bench for seg_scan_capture: scripted scan scenarios plus randomized
// scans, all compared against a frame-level reference model of the display receiver.
`timescale 1ns/1ps
module tb_seg_scan_capture;

  localparam int         SETTLE  = 2;
  localparam int         STABLE  = 2;
  localparam int         TIMEOUT = 4096;
  localparam logic [7:0] IDLE    = 8'hFF;

  logic        clk;
  logic        nrst;
  logic [7:0]  i_com;
  logic [7:0]  i_ens;
  logic [63:0] o_seg;
  logic [31:0] o_hex;
  logic [7:0]  o_hex_ok;
  logic        o_frame_stb;
  logic        o_err;
  logic        o_stall;

  seg_scan_capture #(
    .SETTLE_CYC    (SETTLE),
    .STABLE_FRAMES (STABLE),
    .TIMEOUT_CYC   (TIMEOUT),
    .COM_ACT_LOW   (1)
  ) dut (
    .clk         (clk),
    .nrst        (nrst),
    .i_com       (i_com),
    .i_ens       (i_ens),
    .o_seg       (o_seg),
    .o_hex       (o_hex),
    .o_hex_ok    (o_hex_ok),
    .o_frame_stb (o_frame_stb),
    .o_err       (o_err),
    .o_stall     (o_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int stb_seen = 0;

  always @(negedge clk) begin
    if (o_frame_stb) stb_seen <= stb_seen + 1;
  end

  // Reference model state: one entry per digit.
  logic [6:0] seg_tbl  [16];
  logic [7:0] m_shadow [8];
  logic [7:0] m_prev   [8];
  logic [7:0] m_pub    [8];
  logic [7:0] m_mask;
  int         m_match;
  bit         m_err;
  int         m_strobes;
  logic [7:0] m_last_com;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] ref_decode(input logic [7:0] s);
    logic [4:0] r;
    r = 5'b0_0000;
    if (s[6:0] == 7'h00) r = 5'b1_0000;
    for (int i = 0; i < 16; i++) begin
      if (seg_tbl[i] == s[6:0]) r = {1'b1, 4'(i)};
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 8; k++) begin
      m_shadow[k] = 8'h00;
      m_prev[k]   = 8'h00;
      m_pub[k]    = 8'h00;
    end
    m_mask     = 8'h00;
    m_match    = 0;
    m_err      = 1'b0;
    m_last_com = IDLE;
  endtask

  // A full set of digits has arrived: count identical frames and publish when stable.
  task automatic model_frame();
    bit same;
    same = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (m_shadow[k] != m_prev[k]) same = 1'b0;
    end
    m_match = same ? ((m_match >= STABLE) ? STABLE : m_match + 1) : 1;
    for (int k = 0; k < 8; k++) m_prev[k] = m_shadow[k];
    m_mask = 8'h00;
    if (m_match == STABLE) begin
      for (int k = 0; k < 8; k++) m_pub[k] = m_shadow[k];
      m_strobes++;
    end
  endtask

  // Hold one COM/ENS value for len cycles; a digit is taken if held at least SETTLE cycles.
  task automatic apply_run(input logic [7:0] c, input logic [7:0] e, input int len);
    logic [7:0] act;
    int         idx;
    if (c == m_last_com && c != IDLE) begin
      i_com = IDLE;
      i_ens = 8'h00;
      @(posedge clk); #1;
    end
    act = ~c;
    idx = 0;
    if ($countones(act) >= 2) begin
      m_err = 1'b1;
    end else if ($countones(act) == 1 && len >= SETTLE) begin
      for (int k = 0; k < 8; k++) if (act[k]) idx = k;
      m_shadow[idx] = e;
      m_mask[idx]   = 1'b1;
      if (m_mask == 8'hFF) model_frame();
    end
    i_com = c;
    i_ens = e;
    repeat (len) @(posedge clk);
    #1;
    m_last_com = c;
  endtask

  task automatic scan_range(input logic [63:0] segs, input int lo, input int hi, input int hold);
    for (int k = lo; k <= hi; k++) apply_run(~(8'h01 << k), segs[8*k +: 8], hold);
  endtask

  task automatic settle();
    apply_run(IDLE, 8'h00, 4);
  endtask

  task automatic check_outputs(input string tag);
    logic [63:0] es;
    logic [31:0] eh;
    logic [7:0]  eo;
    logic [4:0]  d;
    for (int k = 0; k < 8; k++) begin
      d            = ref_decode(m_pub[k]);
      es[8*k +: 8] = m_pub[k];
      eh[4*k +: 4] = d[3:0];
      eo[k]        = d[4];
    end
    check_val({tag, "_seg"}, o_seg, es);
    check_val({tag, "_hex"}, {32'd0, o_hex}, {32'd0, eh});
    check_val({tag, "_ok"}, {56'd0, o_hex_ok}, {56'd0, eo});
    check_val({tag, "_err"}, {63'd0, o_err}, {63'd0, m_err});
    check_val({tag, "_stall"}, {63'd0, o_stall}, 64'd0);
    check_val({tag, "_stb_cnt"}, stb_seen, m_strobes);
  endtask

  logic [63:0] pat1;
  logic [63:0] pat2;
  logic [63:0] rpat;
  int          base;

  initial begin
    seg_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    nrst  = 1'b1;
    i_com = IDLE;
    i_ens = 8'h00;
    model_reset();
    m_strobes = 0;
    for (int k = 0; k < 8; k++) pat1[8*k +: 8] = {1'b0, seg_tbl[k+1]};
    pat2 = pat1;
    pat2[31:24] = 8'h7F;

    repeat (3) @(posedge clk);
    #1;
    check_val("rst_seg", o_seg, 64'd0);
    check_val("rst_hex", {32'd0, o_hex}, 64'd0);
    check_val("rst_ok", {56'd0, o_hex_ok}, 64'd0);
    check_val("rst_stb", {63'd0, o_frame_stb}, 64'd0);
    check_val("rst_err", {63'd0, o_err}, 64'd0);
    check_val("rst_stall", {63'd0, o_stall}, 64'd0);
    nrst = 1'b0;
    @(posedge clk); #1;

    // "12345678": publish after the second identical frame, then every frame.
    scan_range(pat1, 0, 7, 4); settle();
    check_val("t1_f1_stb", stb_seen, 0);
    scan_range(pat1, 0, 7, 4); settle();
    check_val("t1_f2_stb", stb_seen, 1);
    check_val("t1_hex", {32'd0, o_hex}, 64'h8765_4321);
    check_val("t1_ok", {56'd0, o_hex_ok}, 64'hFF);
    check_outputs("t1");
    scan_range(pat1, 0, 7, 4); settle();
    check_val("t1_f3_stb", stb_seen, 2);

    // Digit 3 becomes 8: the changed frame must repeat before it is published.
    scan_range(pat2, 0, 7, 4); settle();
    check_val("t2_f3_stb", stb_seen, 2);
    scan_range(pat2, 0, 7, 4); settle();
    check_val("t2_f4_stb", stb_seen, 3);
    check_val("t2_dig3", {60'd0, o_hex[15:12]}, 64'h8);
    check_outputs("t2");

    // Two digits selected at once mid-frame.
    scan_range(pat2, 0, 3, 4);
    apply_run(8'b1111_1100, 8'h00, 1);
    scan_range(pat2, 4, 7, 4); settle();
    check_val("t3_err", {63'd0, o_err}, 64'd1);
    check_outputs("t3");
    scan_range(pat2, 0, 7, 4); settle();
    check_val("t3_err_sticky", {63'd0, o_err}, 64'd1);

    // Digit 5 shown for a single cycle: that frame must not complete.
    base = stb_seen;
    scan_range(pat2, 0, 4, 4);
    apply_run(~8'h20, pat2[47:40], 1);
    scan_range(pat2, 6, 7, 4); settle();
    check_val("t4_no_stb", stb_seen, base);
    scan_range(pat2, 0, 7, 4); settle();
    check_outputs("t4");

    // Frozen COM raises o_stall only after the timeout, and the next change clears it.
    apply_run(~8'h01, pat2[7:0], 4000);
    check_val("t5_pre_stall", {63'd0, o_stall}, 64'd0);
    repeat (200) @(posedge clk);
    #1;
    check_val("t5_stall", {63'd0, o_stall}, 64'd1);
    apply_run(~8'h02, pat2[15:8], 3);
    check_val("t5_stall_clr", {63'd0, o_stall}, 64'd0);
    scan_range(pat2, 2, 7, 4); settle();

    // Reset in the middle of a frame.
    scan_range(pat1, 0, 3, 4);
    nrst = 1'b1;
    #1;
    check_val("t6_seg", o_seg, 64'd0);
    check_val("t6_hex", {32'd0, o_hex}, 64'd0);
    check_val("t6_ok", {56'd0, o_hex_ok}, 64'd0);
    check_val("t6_err", {63'd0, o_err}, 64'd0);
    check_val("t6_stall", {63'd0, o_stall}, 64'd0);
    check_val("t6_stb", {63'd0, o_frame_stb}, 64'd0);
    i_com = IDLE;
    i_ens = 8'h00;
    @(posedge clk); #1;
    nrst = 1'b0;
    model_reset();
    base = stb_seen;
    scan_range(pat1, 0, 7, 4); settle();
    check_val("t6_f1_stb", stb_seen, base);
    scan_range(pat1, 0, 7, 4); settle();
    check_val("t6_f2_stb", stb_seen, base + 1);
    check_outputs("t6");

    // Randomized scans with short holds, glitches and undecodable patterns.
    for (int it = 0; it < 25; it++) begin
      for (int k = 0; k < 8; k++) begin
        int r;
        r = $urandom_range(0, 9);
        if (r < 7)       rpat[8*k +: 8] = {1'($urandom_range(0, 1)), seg_tbl[$urandom_range(0, 15)]};
        else if (r == 7) rpat[8*k +: 8] = {1'($urandom_range(0, 1)), 7'h00};
        else             rpat[8*k +: 8] = 8'($urandom);
      end
      for (int f = 0; f < 3; f++) begin
        for (int k = 0; k < 8; k++) begin
          if ($urandom_range(0, 11) == 0) begin
            int a;
            int b;
            a = $urandom_range(0, 7);
            b = (a + 1 + $urandom_range(0, 6)) % 8;
            apply_run(~((8'h01 << a) | (8'h01 << b)), 8'($urandom), $urandom_range(1, 2));
          end
          apply_run(~(8'h01 << k), rpat[8*k +: 8],
                    ($urandom_range(0, 4) == 0) ? 1 : $urandom_range(2, 5));
        end
      end
      settle();
      check_outputs("rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
